// File: rtl/reg_file_arb.sv
// reg_file_arb: round-robin arbiter merging two requesters onto one credit-flow-controlled register file port.
// Responses return in order and are steered back to their requester via a tag FIFO.
module reg_file_arb #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int ERR_W   = 2,
    parameter int CREDITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wr_data,
    output logic              m0_gnt,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rd_data,
    output logic [ERR_W-1:0]  m0_err,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wr_data,
    output logic              m1_gnt,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic [ERR_W-1:0]  m1_err,
    output logic              o_req,
    output logic              o_wr,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wr_data,
    input  logic [DATA_W-1:0] i_rd_data,
    input  logic              i_ack,
    input  logic              i_credit,
    input  logic [ERR_W-1:0]  i_err,
    output logic              o_busy,
    output logic              o_ack_unexp,
    output logic              o_cred_ovf
);
    localparam int CW = $clog2(CREDITS) + 1;
    localparam int PW = $clog2(CREDITS);

    logic [CW-1:0]      cred, cnt;
    logic [PW-1:0]      wp, rp;
    logic [CREDITS-1:0] tags;
    logic               last, can, issue, pop, head;

    // Grants are gated by rst so every output reads 0 while reset is held.
    always_comb begin
        can    = cred != '0;
        m0_gnt = !rst && can && m0_req && (!m1_req || last);
        m1_gnt = !rst && can && m1_req && (!m0_req || !last);
        issue  = m0_gnt || m1_gnt;
        pop    = i_ack && cnt != '0;
        head   = tags[rp];
        o_busy = cnt != '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cred        <= CW'(CREDITS);
            cnt         <= '0;
            wp          <= '0;
            rp          <= '0;
            tags        <= '0;
            last        <= 1'b1;
            o_req       <= 1'b0;
            o_wr        <= 1'b0;
            o_addr      <= '0;
            o_wr_data   <= '0;
            m0_ack      <= 1'b0;
            m1_ack      <= 1'b0;
            m0_rd_data  <= '0;
            m1_rd_data  <= '0;
            m0_err      <= '0;
            m1_err      <= '0;
            o_ack_unexp <= 1'b0;
            o_cred_ovf  <= 1'b0;
        end else begin
            o_req <= issue;
            if (issue) begin
                o_wr       <= m1_gnt ? m1_wr : m0_wr;
                o_addr     <= m1_gnt ? m1_addr : m0_addr;
                o_wr_data  <= m1_gnt ? m1_wr_data : m0_wr_data;
                tags[wp]   <= m1_gnt;
                wp         <= wp + 1'b1;
                last       <= m1_gnt;
            end
            if (pop)
                rp <= rp + 1'b1;
            cnt <= cnt + CW'(issue) - CW'(pop);
            if (issue && !i_credit)
                cred <= cred - 1'b1;
            else if (!issue && i_credit) begin
                if (cred == CW'(CREDITS))
                    o_cred_ovf <= 1'b1;
                else
                    cred <= cred + 1'b1;
            end
            if (i_ack && cnt == '0)
                o_ack_unexp <= 1'b1;
            m0_ack <= pop && !head;
            m1_ack <= pop && head;
            if (pop && !head) begin
                m0_rd_data <= i_rd_data;
                m0_err     <= i_err;
            end
            if (pop && head) begin
                m1_rd_data <= i_rd_data;
                m1_err     <= i_err;
            end
        end
    end
endmodule

// File: tb/tb_reg_file_arb.sv
// tb_reg_file_arb: scoreboard bench; a transaction-level model predicts issues and responses,
// and a negedge monitor pops and compares whenever the DUT presents o_req or an ack.
module tb_reg_file_arb;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int EW = 2;
    localparam int C  = 4;

    logic          clk = 0, rst = 1;
    logic          m0_req = 0, m0_wr = 0, m1_req = 0, m1_wr = 0;
    logic [AW-1:0] m0_addr = 0, m1_addr = 0, o_addr;
    logic [DW-1:0] m0_wr_data = 0, m1_wr_data = 0, o_wr_data, i_rd_data = 0;
    logic [DW-1:0] m0_rd_data, m1_rd_data;
    logic [EW-1:0] m0_err, m1_err, i_err = 0;
    logic          m0_gnt, m0_ack, m1_gnt, m1_ack, o_req, o_wr;
    logic          i_ack = 0, i_credit = 0, o_busy, o_ack_unexp, o_cred_ovf;

    reg_file_arb #(.ADDR_W(AW), .DATA_W(DW), .ERR_W(EW), .CREDITS(C)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
        .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rd_data(m0_rd_data), .m0_err(m0_err),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
        .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rd_data(m1_rd_data), .m1_err(m1_err),
        .o_req(o_req), .o_wr(o_wr), .o_addr(o_addr), .o_wr_data(o_wr_data),
        .i_rd_data(i_rd_data), .i_ack(i_ack), .i_credit(i_credit), .i_err(i_err),
        .o_busy(o_busy), .o_ack_unexp(o_ack_unexp), .o_cred_ovf(o_cred_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {logic wr; logic [AW-1:0] addr; logic [DW-1:0] data;} iss_t;
    typedef struct {logic id; logic [DW-1:0] d; logic [EW-1:0] e;} ack_t;

    iss_t exp_iss[$];
    ack_t exp_ack[$];
    int checks = 0, errors = 0;
    int mcred = C;
    bit mlast = 1, munexp = 0, movf = 0;
    bit mfifo[$];
    int cyc_n = 0, oreq_cnt = 0, base;
    int resp[$];
    int gnt_log[$];
    bit auto_resp = 0, log_on = 0;
    logic [DW-1:0] last_rd[2];
    logic [EW-1:0] last_err[2];
    iss_t mi;
    ack_t ma;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            last_rd  = '{default: '0};
            last_err = '{default: '0};
        end else begin
            if (o_req) begin
                oreq_cnt++;
                if (exp_iss.size() == 0) chk("spurious o_req", 1, 0);
                else begin
                    mi = exp_iss.pop_front();
                    chk("o_wr", o_wr, mi.wr);
                    chk("o_addr", o_addr, mi.addr);
                    chk("o_wr_data", o_wr_data, mi.data);
                end
            end
            chk("dual ack", m0_ack & m1_ack, 0);
            if (m0_ack | m1_ack) begin
                if (exp_ack.size() == 0) chk("spurious ack", 1, 0);
                else begin
                    ma = exp_ack.pop_front();
                    chk("ack id", m1_ack, ma.id);
                    chk("rd_data", m1_ack ? m1_rd_data : m0_rd_data, ma.d);
                    chk("err", m1_ack ? m1_err : m0_err, ma.e);
                end
            end
            if (!m0_ack) begin
                chk("m0 hold data", m0_rd_data, last_rd[0]);
                chk("m0 hold err", m0_err, last_err[0]);
            end
            if (!m1_ack) begin
                chk("m1 hold data", m1_rd_data, last_rd[1]);
                chk("m1 hold err", m1_err, last_err[1]);
            end
            last_rd[0] = m0_rd_data; last_err[0] = m0_err;
            last_rd[1] = m1_rd_data; last_err[1] = m1_err;
        end
    end

    // Entered and left at posedge+1; evaluates the model at posedge+4.
    task automatic step();
        bit e0, e1, iss;
        ack_t a;
        iss_t x;
        #3;
        e0 = mcred > 0 && m0_req && (!m1_req || mlast);
        e1 = mcred > 0 && m1_req && (!m0_req || !mlast);
        iss = e0 | e1;
        chk("m0_gnt", m0_gnt, e0);
        chk("m1_gnt", m1_gnt, e1);
        chk("o_busy", o_busy, mfifo.size() != 0);
        chk("o_ack_unexp", o_ack_unexp, munexp);
        chk("o_cred_ovf", o_cred_ovf, movf);
        if (log_on && (m0_gnt | m1_gnt)) gnt_log.push_back(int'(m1_gnt));
        if (i_ack) begin
            if (mfifo.size() != 0) begin
                a.id = mfifo.pop_front(); a.d = i_rd_data; a.e = i_err;
                exp_ack.push_back(a);
            end else munexp = 1;
        end
        if (iss) begin
            x.wr = e1 ? m1_wr : m0_wr;
            x.addr = e1 ? m1_addr : m0_addr;
            x.data = e1 ? m1_wr_data : m0_wr_data;
            exp_iss.push_back(x);
            mfifo.push_back(e1);
            mlast = e1;
            if (auto_resp) resp.push_back(cyc_n + 3);
        end
        if (iss && !i_credit) mcred--;
        else if (!iss && i_credit) begin
            if (mcred == C) movf = 1;
            else mcred++;
        end
        @(posedge clk); #1;
        cyc_n++;
        i_ack = 0; i_credit = 0;
        if (e0) m0_req = 0;
        if (e1) m1_req = 0;
        if (auto_resp && resp.size() != 0 && resp[0] == cyc_n) begin
            void'(resp.pop_front());
            i_ack = 1; i_credit = 1; i_rd_data = $urandom; i_err = EW'($urandom);
        end
    endtask

    task automatic do_reset();
        rst = 1;
        m0_req = 1; m1_req = 1; i_ack = 0; i_credit = 0;
        exp_iss.delete(); exp_ack.delete(); mfifo.delete(); resp.delete();
        mcred = C; mlast = 1; munexp = 0; movf = 0;
        #3;
        chk("rst m0 outs", |{m0_gnt, m0_ack, m0_rd_data, m0_err}, 0);
        chk("rst m1 outs", |{m1_gnt, m1_ack, m1_rd_data, m1_err}, 0);
        chk("rst o outs", |{o_req, o_wr, o_addr, o_wr_data, o_busy, o_ack_unexp, o_cred_ovf}, 0);
        m0_req = 0; m1_req = 0;
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic set_m0(input logic wr);
        m0_req = 1; m0_wr = wr; m0_addr = AW'($urandom); m0_wr_data = $urandom;
    endtask

    task automatic set_m1(input logic wr);
        m1_req = 1; m1_wr = wr; m1_addr = AW'($urandom); m1_wr_data = $urandom;
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset();

        // Both requesters held from reset, responses two cycles after each o_req.
        auto_resp = 1; log_on = 1;
        repeat (8) begin
            if (!m0_req) set_m0($urandom);
            if (!m1_req) set_m1($urandom);
            step();
        end
        repeat (6) step();
        auto_resp = 0; log_on = 0;
        if (gnt_log.size() < 4) chk("gnt log length", gnt_log.size(), 4);
        else for (int i = 0; i < 4; i++) chk("gnt order", gnt_log[i], i % 2);

        // Credit exhaustion and a single credit return.
        do_reset();
        base = oreq_cnt;
        repeat (10) begin set_m0(0); step(); end
        chk("issues without credit", oreq_cnt - base, 4);
        i_credit = 1; set_m0(0); step();
        repeat (6) begin set_m0(0); step(); end
        chk("issues after one credit", oreq_cnt - base, 5);
        m0_req = 0;

        // Directed write on m1, then error response routed to m0.
        do_reset();
        m1_req = 1; m1_wr = 1; m1_addr = 8'h10; m1_wr_data = 32'hDEADBEEF;
        step();
        chk("dir o_req", o_req, 1);
        chk("dir o_wr", o_wr, 1);
        chk("dir o_addr", o_addr, 8'h10);
        chk("dir o_wr_data", o_wr_data, 32'hDEADBEEF);
        set_m0(0); step();
        i_ack = 1; i_credit = 1; i_rd_data = 32'h1111_2222; i_err = 2'b00; step();
        i_ack = 1; i_credit = 1; i_rd_data = 32'hCAFE_F00D; i_err = 2'b01; step();
        chk("err m0_ack", m0_ack, 1);
        chk("err m0_err", m0_err, 2'b01);
        chk("err m1_ack", m1_ack, 0);
        step();

        // Unexpected ack and credit overflow after reset; counter must still allow exactly 4.
        do_reset();
        i_ack = 1; step();
        chk("unexp flag", o_ack_unexp, 1);
        chk("unexp no ack", m0_ack | m1_ack, 0);
        i_credit = 1; step();
        chk("ovf flag", o_cred_ovf, 1);
        base = oreq_cnt;
        repeat (8) begin set_m0($urandom); step(); end
        chk("issues after ovf", oreq_cnt - base, 4);
        m0_req = 0;

        // Reset with three outstanding discards them.
        do_reset();
        repeat (3) begin set_m1($urandom); step(); end
        chk("busy before rst", o_busy, 1);
        m1_req = 0;
        do_reset();
        chk("busy after rst", o_busy, 0);
        i_ack = 1; step();
        chk("unexp after rst", o_ack_unexp, 1);
        i_credit = 1; step();
        chk("ovf after rst", o_cred_ovf, 1);
        base = oreq_cnt;
        repeat (8) begin set_m0($urandom); step(); end
        chk("issues after rst", oreq_cnt - base, 4);
        m0_req = 0;

        // Randomized traffic with credits kept consistent with outstanding requests.
        do_reset();
        repeat (1500) begin
            if (!m0_req && $urandom_range(0, 2) == 0) set_m0($urandom);
            else if (m0_req && $urandom_range(0, 15) == 0) m0_req = 0;
            if (!m1_req && $urandom_range(0, 2) == 0) set_m1($urandom);
            else if (m1_req && $urandom_range(0, 15) == 0) m1_req = 0;
            if (mfifo.size() != 0 ? $urandom_range(0, 2) == 0 : $urandom_range(0, 60) == 0) begin
                i_ack = 1; i_rd_data = $urandom; i_err = EW'($urandom);
            end
            if (mcred + mfifo.size() < C ? $urandom_range(0, 1) == 0
                : (mcred == C && !m0_req && !m1_req && $urandom_range(0, 60) == 0))
                i_credit = 1;
            step();
        end
        m0_req = 0; m1_req = 0;
        repeat (20) begin
            if (mfifo.size() != 0) begin
                i_ack = 1; i_rd_data = $urandom; i_err = EW'($urandom);
            end
            step();
        end
        chk("issue queue drained", exp_iss.size(), 0);
        chk("ack queue drained", exp_ack.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_file_arb.md
REG_FILE_ARB -- requirements
Module: reg_file_arb

Interface
REQ-001 The block SHALL have parameters: ADDR_W, default 8, register address width; DATA_W, default 32, data width; ERR_W, default 2, error code width; CREDITS, default 4, maximum outstanding register-file requests (power of 2, 2..16).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 The block SHALL have these ports:
 clk  in  1  clock
 rst  in  1  asynchronous active-high reset
 m0_req  in  1  requester 0 request; held with fields until m0_gnt
 m0_wr  in  1  requester 0 write(1)/read(0)
 m0_addr  in  ADDR_W  requester 0 address
 m0_wr_data  in  DATA_W  requester 0 write data
 m0_gnt  out  1  requester 0 request accepted this cycle
 m0_ack  out  1  requester 0 response valid
 m0_rd_data  out  DATA_W  requester 0 read data
 m0_err  out  ERR_W  requester 0 error code
 m1_*  same as m0_*  requester 1
 o_req  out  1  request to register file
 o_wr  out  1  write(1)/read(0) to register file
 o_addr  out  ADDR_W  address to register file
 o_wr_data  out  DATA_W  write data to register file
 i_rd_data  in  DATA_W  register-file read data
 i_ack  in  1  register-file response valid
 i_credit  in  1  register-file credit return, one per pulse
 i_err  in  ERR_W  register-file error code
 o_busy  out  1  one or more requests outstanding
 o_ack_unexp  out  1  sticky: i_ack received with nothing outstanding
 o_cred_ovf  out  1  sticky: i_credit received with counter full

Function
REQ-004 A credit counter, width clog2(CREDITS)+1, SHALL reset to CREDITS; a request is issued only when the counter is non-zero.
REQ-005 Issue SHALL decrement the counter and i_credit SHALL increment it; both in one cycle SHALL leave it unchanged.
REQ-006 i_credit with counter at CREDITS and no issue that cycle SHALL leave the counter at CREDITS and set o_cred_ovf.
REQ-007 Arbitration SHALL be round-robin: one requester asserting req wins; when both assert, the one not granted last wins; last-granted pointer resets to 1, so requester 0 wins the first tie.
REQ-008 mX_gnt SHALL be combinational, asserted in the cycle mX_req=1, the requester wins and credit>0; at most one gnt per cycle.
REQ-009 On the clock edge ending a gnt cycle, o_req SHALL register 1 and o_wr/o_addr/o_wr_data SHALL register the winner's fields (1-cycle issue latency); o_req SHALL be 0 in cycles with no gnt.
REQ-010 Each issue SHALL push the winner's ID into an in-order tag FIFO of depth CREDITS; the FIFO cannot overflow because credit bounds outstanding requests.
REQ-011 Each i_ack with the FIFO non-empty SHALL pop the head ID; on the next edge mID_ack=1 and mID_rd_data/mID_err SHALL register i_rd_data/i_err; the other requester's ack SHALL be 0.
REQ-012 Push and pop in the same cycle SHALL both take effect; FIFO read and write pointers wrap modulo CREDITS.
REQ-013 i_ack with the FIFO empty SHALL be dropped (no mX_ack) and SHALL set o_ack_unexp.
REQ-014 mX_rd_data/mX_err SHALL hold their last value when mX_ack=0.
REQ-015 o_busy SHALL equal FIFO non-empty.
REQ-016 A requester deasserting req before gnt SHALL not be issued; the pointer is unchanged.

Reset
REQ-017 While rst=1: all outputs SHALL be 0; credit counter=CREDITS; FIFO empty; pointer=1; sticky flags cleared.
REQ-018 Reset mid-operation SHALL discard outstanding requests; later i_ack SHALL set o_ack_unexp and later i_credit at full SHALL set o_cred_ovf.

Verification
REQ-019 Bench SHALL cover: both req held from reset with i_ack/i_credit returned 2 cycles after each o_req -> gnt order m0,m1,m0,m1; each mX_ack returns that requester's i_rd_data.
REQ-020 Bench SHALL cover: CREDITS=4, m0_req held, no i_credit -> exactly 4 o_req pulses then gnt=0; one i_credit -> exactly one further o_req.
REQ-021 Bench SHALL cover: m1 write addr 0x10 data 0xDEADBEEF -> o_req=1, o_wr=1, o_addr=0x10, o_wr_data=0xDEADBEEF one cycle after m1_gnt.
REQ-022 Bench SHALL cover: i_ack with i_err=2'b01 while head ID=0 -> m0_ack=1, m0_err=2'b01 next cycle, m1_ack=0.
REQ-023 Bench SHALL cover: i_ack after reset with nothing issued -> o_ack_unexp=1, no mX_ack; i_credit at full -> o_cred_ovf=1, counter stays 4.
REQ-024 Bench SHALL cover: rst pulsed with 3 outstanding -> o_busy=0, counter=4, 4 new requests issue without credit return.
